// File: rtl/ram_fetch_ctrl.sv
// Parameter-RAM fetch sequencer: optional RAM init handshake, then a strided read burst streamed out through a 2-entry buffer.
// Optional feature: define RAM_FETCH_PERF_EN to enable the backpressure stall counter on perf_stall_cnt.
module ram_fetch_ctrl #(
    parameter int DW       = 8,
    parameter int ADDR_DW  = 5,
    parameter int RAM_SIZE = 32,
    parameter int LEN_W    = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               init_req,
    input  logic [31:0]        para_in,
    input  logic [ADDR_DW-1:0] base_addr,
    input  logic [ADDR_DW-1:0] stride,
    input  logic [LEN_W-1:0]   len,
    output logic               busy,
    output logic               done,
    output logic               ram_initial_sig,
    output logic [31:0]        ram_para,
    output logic               ram_RAenable,
    output logic [ADDR_DW-1:0] ram_addr,
    input  logic [DW-1:0]      ram_dout,
    input  logic               ram_mem_initial_signal,
    output logic [DW-1:0]      out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_last,
    output logic [15:0]        perf_stall_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_INIT_WAIT,
        S_READ,
        S_DRAIN,
        S_FIN
    } state_t;

    state_t             state_q;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   issueCnt_q;
    logic [ADDR_DW-1:0] addr_q;
    logic [ADDR_DW-1:0] stride_q;
    logic [31:0]        para_q;
    logic               busy_q;
    logic               done_q;
    logic               ramInit_q;

    logic               inflight_q;
    logic               inflightLast_q;
    logic [DW-1:0]      fifoData_q [2];
    logic               fifoLast_q [2];
    logic               rdPtr_q;
    logic               wrPtr_q;
    logic [1:0]         count_q;
    logic [1:0]         count_d;

    logic               pop;
    logic               push;
    logic [2:0]         effOcc;
    logic               issue;
    logic               issueLast;
    logic [LEN_W-1:0]   lenClamped;

    // A pop this cycle frees a slot for the read issued now, which keeps the stream gapless at full rate.
    always_comb begin
        pop       = (count_q != 2'd0) && out_ready;
        push      = inflight_q;
        effOcc    = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
        issue     = (state_q == S_READ) && (effOcc < 3'd2);
        issueLast = issue && (issueCnt_q == (len_q - LEN_W'(1)));
        count_d   = count_q + {1'b0, push} - {1'b0, pop};
        lenClamped = (len > LEN_W'(RAM_SIZE)) ? LEN_W'(RAM_SIZE) : len;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            issueCnt_q <= '0;
            addr_q     <= '0;
            stride_q   <= '0;
            para_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ramInit_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        len_q      <= lenClamped;
                        stride_q   <= stride;
                        addr_q     <= base_addr;
                        issueCnt_q <= '0;
                        if (init_req) begin
                            para_q    <= para_in;
                            ramInit_q <= 1'b1;
                            busy_q    <= 1'b1;
                            state_q   <= S_INIT;
                        end else if (len != '0) begin
                            busy_q  <= 1'b1;
                            state_q <= S_READ;
                        end else begin
                            done_q  <= 1'b1;
                            state_q <= S_FIN;
                        end
                    end
                end
                S_INIT: begin
                    ramInit_q <= 1'b0;
                    state_q   <= S_INIT_WAIT;
                end
                S_INIT_WAIT: begin
                    if (ram_mem_initial_signal) begin
                        if (len_q != '0) begin
                            state_q <= S_READ;
                        end else begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            para_q  <= '0;
                            state_q <= S_FIN;
                        end
                    end
                end
                S_READ: begin
                    if (issue) begin
                        addr_q     <= addr_q + stride_q;
                        issueCnt_q <= issueCnt_q + LEN_W'(1);
                        if (issueLast) begin
                            state_q <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (!inflight_q && (count_q == 2'd0)) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        para_q  <= '0;
                        state_q <= S_FIN;
                    end
                end
                S_FIN: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // The RAM returns data one cycle after the issue, so the in-flight flag marks the capture cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_q     <= 1'b0;
            inflightLast_q <= 1'b0;
            rdPtr_q        <= 1'b0;
            wrPtr_q        <= 1'b0;
            count_q        <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                fifoData_q[i] <= '0;
                fifoLast_q[i] <= 1'b0;
            end
        end else begin
            inflight_q     <= issue;
            inflightLast_q <= issueLast;
            if (push) begin
                fifoData_q[wrPtr_q] <= ram_dout;
                fifoLast_q[wrPtr_q] <= inflightLast_q;
                wrPtr_q             <= ~wrPtr_q;
            end
            if (pop) begin
                rdPtr_q <= ~rdPtr_q;
            end
            count_q <= count_d;
        end
    end

`ifdef RAM_FETCH_PERF_EN
    logic [15:0] stallCnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stallCnt_q <= '0;
        end else if ((state_q == S_IDLE) && start) begin
            stallCnt_q <= '0;
        end else if ((state_q == S_READ) && !issue && (stallCnt_q != 16'hFFFF)) begin
            stallCnt_q <= stallCnt_q + 16'd1;
        end
    end

    assign perf_stall_cnt = stallCnt_q;
`else
    assign perf_stall_cnt = 16'd0;
`endif

    assign busy            = busy_q;
    assign done            = done_q;
    assign ram_initial_sig = ramInit_q;
    assign ram_para        = para_q;
    assign ram_RAenable    = issue;
    assign ram_addr        = addr_q;
    assign out_valid       = (count_q != 2'd0);
    assign out_data        = out_valid ? fifoData_q[rdPtr_q] : '0;
    assign out_last        = out_valid & fifoLast_q[rdPtr_q];

endmodule

// File: tb/tb_ram_fetch_ctrl.sv
// Self-checking bench for ram_fetch_ctrl: behavioural RAM, a per-burst scoreboard and directed scenarios.
module tb_ram_fetch_ctrl;

    localparam int DW       = 8;
    localparam int ADDR_DW  = 5;
    localparam int RAM_SIZE = 32;
    localparam int LEN_W    = 6;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic               init_req;
    logic [31:0]        para_in;
    logic [ADDR_DW-1:0] base_addr;
    logic [ADDR_DW-1:0] stride;
    logic [LEN_W-1:0]   len;
    logic               busy;
    logic               done;
    logic               ram_initial_sig;
    logic [31:0]        ram_para;
    logic               ram_RAenable;
    logic [ADDR_DW-1:0] ram_addr;
    logic [DW-1:0]      ram_dout = '0;
    logic               ram_mem_initial_signal = 1'b0;
    logic [DW-1:0]      out_data;
    logic               out_valid;
    logic               out_ready;
    logic               out_last;
    logic [15:0]        perf_stall_cnt;

    int vecCount = 0;
    int errCount = 0;

    ram_fetch_ctrl #(.DW(DW), .ADDR_DW(ADDR_DW), .RAM_SIZE(RAM_SIZE), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst), .start(start), .init_req(init_req), .para_in(para_in),
        .base_addr(base_addr), .stride(stride), .len(len), .busy(busy), .done(done),
        .ram_initial_sig(ram_initial_sig), .ram_para(ram_para), .ram_RAenable(ram_RAenable),
        .ram_addr(ram_addr), .ram_dout(ram_dout), .ram_mem_initial_signal(ram_mem_initial_signal),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .perf_stall_cnt(perf_stall_cnt)
    );

    always #5 clk = ~clk;

    // RAM contents are a fixed pattern XORed with the low byte of the last init seed.
    function automatic logic [7:0] pattern(input int a);
        case (a)
            0:       return 8'h01;
            1:       return 8'hFC;
            2:       return 8'hFE;
            3:       return 8'h01;
            default: return 8'(a * 7 + 3);
        endcase
    endfunction

    logic [7:0] ramSeed = 8'h00;
    int         ackCnt  = 0;

    always @(posedge clk) begin
        ram_mem_initial_signal <= 1'b0;
        if (ram_initial_sig) begin
            ramSeed <= ram_para[7:0];
            ackCnt  <= 3;
        end else if (ackCnt != 0) begin
            ackCnt <= ackCnt - 1;
            if (ackCnt == 1) ram_mem_initial_signal <= 1'b1;
        end
        if (ram_RAenable) ram_dout <= pattern(int'(ram_addr)) ^ ramSeed;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vecCount++;
        if (actual !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
        end
    endtask

    task automatic failNow(input string name);
        vecCount++;
        errCount++;
        $display("[TB] FAIL %s: actual=event required=none", name);
    endtask

    // Scoreboard and logs
    int         expAddrQ[$];
    logic [8:0] expDataQ[$];
    int         addrLog[$];
    logic [7:0] dataLog[$];
    logic       lastLog[$];
    int         acceptCyc[$];
    int         doneCount   = 0;
    int         initPulses  = 0;
    int         outstanding = 0;
    int         cycle       = 0;
    logic [7:0] curSeed     = 8'h00;
    logic [31:0] seedQ      = '0;
    logic       paraCheck   = 1'b0;
    logic       prevStall   = 1'b0;
    logic [7:0] prevData    = '0;
    logic       prevLast    = 1'b0;
    logic [8:0] expEntry;
    int         expA;

    always @(negedge clk) begin
        cycle++;
        if (!rst) begin
            if (ram_initial_sig) initPulses++;
            if (done) begin
                doneCount++;
                checkOutput("busy_on_done", busy, 0);
            end
            if (busy && paraCheck) checkOutput("ram_para", ram_para, seedQ);
            if (prevStall) begin
                checkOutput("stall_valid", out_valid, 1);
                checkOutput("stall_data", out_data, prevData);
                checkOutput("stall_last", out_last, prevLast);
            end
            if (out_valid && out_ready) begin
                if (expDataQ.size() == 0) begin
                    failNow("unexpected_beat");
                end else begin
                    expEntry = expDataQ.pop_front();
                    checkOutput("out_data", out_data, expEntry[7:0]);
                    checkOutput("out_last", out_last, expEntry[8]);
                end
                dataLog.push_back(out_data);
                lastLog.push_back(out_last);
                acceptCyc.push_back(cycle);
                outstanding--;
            end
            if (ram_RAenable) begin
                if (expAddrQ.size() == 0) begin
                    failNow("unexpected_issue");
                end else begin
                    expA = expAddrQ.pop_front();
                    checkOutput("ram_addr", ram_addr, expA);
                end
                addrLog.push_back(int'(ram_addr));
                outstanding++;
                checkOutput("outstanding_over_2", outstanding > 2, 0);
            end
            prevStall = out_valid && !out_ready;
            prevData  = out_data;
            prevLast  = out_last;
        end
    end

    task automatic clearLogs();
        addrLog.delete();
        dataLog.delete();
        lastLog.delete();
        acceptCyc.delete();
        doneCount  = 0;
        initPulses = 0;
    endtask

    task automatic resetModel();
        expAddrQ.delete();
        expDataQ.delete();
        outstanding = 0;
        prevStall   = 1'b0;
        paraCheck   = 1'b0;
    endtask

    // Drives a one-cycle start; when the DUT is idle the burst is loaded into the scoreboard.
    task automatic applyStimulus(input logic ireq, input logic [31:0] seed, input logic [4:0] b,
                                 input logic [4:0] s, input logic [5:0] l, input logic accepted);
        logic [8:0] ent;
        int a;
        init_req  = ireq;
        para_in   = seed;
        base_addr = b;
        stride    = s;
        len       = l;
        start     = 1'b1;
        if (accepted) begin
            if (ireq) curSeed = seed[7:0];
            paraCheck = ireq;
            seedQ     = seed;
            for (int k = 0; k < int'(l); k++) begin
                a = (int'(b) + k * int'(s)) % RAM_SIZE;
                expAddrQ.push_back(a);
                ent[7:0] = pattern(a) ^ curSeed;
                ent[8]   = (k == int'(l) - 1);
                expDataQ.push_back(ent);
            end
        end
        @(posedge clk);
        #1;
        start     = 1'b0;
        init_req  = 1'b1;
        para_in   = 32'hA5A5_A5A5;
        base_addr = 5'd17;
        stride    = 5'd13;
        len       = 6'h3F;
    endtask

    logic [3:0] readyPat = 4'hF;

    task automatic waitDone(input int maxCycles);
        int  n    = 0;
        int  ph   = 0;
        bit  seen = 0;
        while (!seen && n < maxCycles) begin
            out_ready = readyPat[ph % 4];
            ph++;
            @(posedge clk);
            #1;
            n++;
            if (done) seen = 1;
        end
        if (!seen) failNow("done_timeout");
        out_ready = 1'b1;
    endtask

    task automatic settle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    logic [7:0] t1Exp [4];
    int         t2Exp [4];
    int         t6Exp [5];

    initial begin
        int n;
        t1Exp = '{8'h01, 8'hFC, 8'hFE, 8'h01};
        t2Exp = '{30, 1, 4, 7};
        t6Exp = '{2, 7, 12, 17, 22};
        rst = 1'b1; start = 1'b0; init_req = 1'b0; para_in = '0;
        base_addr = '0; stride = '0; len = '0; out_ready = 1'b1;
        settle(3);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_valid", out_valid, 0);
        checkOutput("rst_raen", ram_RAenable, 0);
        checkOutput("rst_init", ram_initial_sig, 0);
        checkOutput("rst_addr", ram_addr, 0);
        checkOutput("rst_data", out_data, 0);
        rst = 1'b0;
        settle(2);

        $display("[TB] init plus full-rate burst");
        clearLogs();
        readyPat = 4'hF;
        applyStimulus(1'b1, 32'h0, 5'd0, 5'd1, 6'd4, 1'b1);
        waitDone(200);
        settle(2);
        checkOutput("t1_count", dataLog.size(), 4);
        for (int i = 0; i < 4 && i < dataLog.size(); i++) begin
            checkOutput("t1_data_lit", dataLog[i], t1Exp[i]);
            checkOutput("t1_last_lit", lastLog[i], (i == 3));
        end
        for (int i = 1; i < acceptCyc.size(); i++)
            checkOutput("t1_gapless", acceptCyc[i] - acceptCyc[i-1], 1);
        checkOutput("t1_init_pulses", initPulses, 1);
        checkOutput("t1_done_pulses", doneCount, 1);
        checkOutput("t1_perf", perf_stall_cnt, 0);
        checkOutput("t1_drained", expDataQ.size(), 0);

        $display("[TB] stride wrap");
        clearLogs();
        applyStimulus(1'b0, 32'hDEAD_BEEF, 5'd30, 5'd3, 6'd4, 1'b1);
        waitDone(200);
        settle(2);
        checkOutput("t2_issues", addrLog.size(), 4);
        for (int i = 0; i < 4 && i < addrLog.size(); i++)
            checkOutput("t2_addr_lit", addrLog[i], t2Exp[i]);
        checkOutput("t2_done_pulses", doneCount, 1);

        $display("[TB] backpressure");
        clearLogs();
        readyPat = 4'b1001;
        applyStimulus(1'b0, 32'h0, 5'd5, 5'd2, 6'd6, 1'b1);
        waitDone(400);
        settle(2);
        readyPat = 4'hF;
        checkOutput("t3_count", dataLog.size(), 6);
        checkOutput("t3_drained", expDataQ.size(), 0);
        checkOutput("t3_done_pulses", doneCount, 1);
`ifdef RAM_FETCH_PERF_EN
        checkOutput("t3_perf_nonzero", perf_stall_cnt != 16'd0, 1);
`else
        checkOutput("t3_perf_tied", perf_stall_cnt, 0);
`endif

        $display("[TB] zero length with init");
        clearLogs();
        applyStimulus(1'b1, 32'h1234_5678, 5'd3, 5'd1, 6'd0, 1'b1);
        waitDone(200);
        settle(2);
        checkOutput("t4_init_pulses", initPulses, 1);
        checkOutput("t4_no_reads", addrLog.size(), 0);
        checkOutput("t4_done_pulses", doneCount, 1);

        $display("[TB] reset mid-burst");
        clearLogs();
        applyStimulus(1'b0, 32'h0, 5'd0, 5'd1, 6'd8, 1'b1);
        n = 0;
        for (int c = 0; c < 50 && n < 3; c++) begin
            if (ram_RAenable) n++;
            if (n < 3) settle(1);
        end
        if (n < 3) failNow("t5_third_read_timeout");
        rst = 1'b1;
        settle(1);
        checkOutput("t5_busy", busy, 0);
        checkOutput("t5_done", done, 0);
        checkOutput("t5_valid", out_valid, 0);
        checkOutput("t5_data", out_data, 0);
        checkOutput("t5_last", out_last, 0);
        checkOutput("t5_raen", ram_RAenable, 0);
        checkOutput("t5_addr", ram_addr, 0);
        checkOutput("t5_init", ram_initial_sig, 0);
        checkOutput("t5_para", ram_para, 0);
        checkOutput("t5_perf", perf_stall_cnt, 0);
        rst = 1'b0;
        resetModel();
        clearLogs();
        settle(4);
        checkOutput("t5_no_done", doneCount, 0);
        applyStimulus(1'b0, 32'h0, 5'd10, 5'd1, 6'd2, 1'b1);
        waitDone(200);
        settle(2);
        checkOutput("t5_restart_count", dataLog.size(), 2);
        checkOutput("t5_restart_done", doneCount, 1);

        $display("[TB] start while busy");
        clearLogs();
        applyStimulus(1'b0, 32'h0, 5'd2, 5'd5, 6'd5, 1'b1);
        settle(2);
        checkOutput("t6_busy_mid", busy, 1);
        applyStimulus(1'b1, 32'hFFFF_FFFF, 5'd9, 5'd1, 6'd1, 1'b0);
        waitDone(200);
        settle(2);
        checkOutput("t6_issues", addrLog.size(), 5);
        for (int i = 0; i < 5 && i < addrLog.size(); i++)
            checkOutput("t6_addr_lit", addrLog[i], t6Exp[i]);
        checkOutput("t6_done_pulses", doneCount, 1);
        checkOutput("t6_init_pulses", initPulses, 0);
        checkOutput("t6_drained", expDataQ.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/ram_fetch_ctrl.md
Name: ram_fetch_ctrl

Overview:
Sequencer for the on-chip parameter RAM that feeds the systolic array.
- On request, runs the RAM's initialisation handshake first.
- Then issues a strided burst of reads: base, stride, length.
- Returns read data as a valid/ready stream with a last marker, using a 2-entry buffer that absorbs the RAM's 1-cycle read latency under backpressure.
- Sits between the layer scheduler (start/done) and one RAM instance.

Parameters:
- DW, 8, RAM data width.
- ADDR_DW, 5, RAM address width.
- RAM_SIZE, 32, RAM depth; must equal 2**ADDR_DW.
- LEN_W, 6, width of burst length (max burst RAM_SIZE).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- init_req  in  1  sampled with start; 1 = run RAM init before the burst.
- para_in  in  32  init seed, forwarded to the RAM during init.
- base_addr  in  ADDR_DW  first read address, sampled with start.
- stride  in  ADDR_DW  address increment, sampled with start.
- len  in  LEN_W  number of reads, sampled with start.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle completion pulse.
- ram_initial_sig  out  1  to RAM initial_sig.
- ram_para  out  32  to RAM para.
- ram_RAenable  out  1  to RAM read enable.
- ram_addr  out  ADDR_DW  to RAM addr.
- ram_dout  in  DW  from RAM data out.
- ram_mem_initial_signal  in  1  from RAM init acknowledge.
- out_data  out  DW  stream data.
- out_valid  out  1  stream valid.
- out_ready  in  1  stream ready.
- out_last  out  1  high with the final element.
- perf_stall_cnt  out  16  see Optional Feature.

Behaviour:
Reset:
- All outputs 0; state IDLE; buffer empty; in-flight flag cleared.
- Reset mid-burst aborts immediately; no done pulse.

State machine:
- IDLE: on start, latch init_req, para_in, base_addr, stride, len; busy goes high next cycle. Next state is INIT if init_req, else READ if len!=0, else FIN.
- INIT: assert ram_initial_sig=1 for exactly one cycle; ram_para holds the latched seed for the whole busy period. Go to INIT_WAIT.
- INIT_WAIT: ram_initial_sig=0. When ram_mem_initial_signal==1, go to READ (len!=0) or FIN (len==0). No timeout.
- READ: issue one read per cycle when (buffer occupancy + in-flight) < 2. Issue means ram_RAenable=1 with ram_addr = base + k*stride mod 2**ADDR_DW, wrapping silently. After the len-th issue, go to DRAIN.
- DRAIN: wait until the in-flight read has landed and the buffer is empty, then go to FIN.
- FIN: done=1 for one cycle; busy=0 in the same cycle. Go to IDLE.

Read path and output stream:
- ram_RAenable is 0 in every cycle without an issue.
- Read data is captured from ram_dout exactly one cycle after its issue cycle.
- The 2-entry FIFO feeds out_data/out_valid. out_data and out_last hold stable while out_valid=1 and out_ready=0.
- out_last=1 only on element len-1.
- Same-cycle pop and capture is legal. Full-rate throughput is one element per cycle when out_ready is held at 1.

Other rules:
- start while busy is ignored. Inputs other than out_ready and RAM returns are don't-care while busy.
- Read data is passed through unmodified; signed values keep their raw two's-complement bits.

Optional Feature:
Macro RAM_FETCH_PERF_EN.
- Defined: perf_stall_cnt counts cycles in READ where an issue was blocked by backpressure. It saturates at 16'hFFFF, clears on an accepted start, and holds its value after done.
- Not defined: perf_stall_cnt is tied to 0 and the counter logic is absent.

Test Plan:
1. Init plus full-rate burst: start with init_req=1, para_in=0, base=0, stride=1, len=4, out_ready=1. Exactly one ram_initial_sig pulse; stream 8'h01, 8'hFC, 8'hFE, 8'h01; out_last on the 4th element; one done pulse; no gaps between elements.
2. Stride wrap: init_req=0, base=30, stride=3, len=4. ram_addr sequence 30, 1, 4, 7.
3. Backpressure: len=6 with out_ready toggling 1,0,0,1. No element lost or duplicated; data stable while stalled; at most 2 reads outstanding. With RAM_FETCH_PERF_EN defined, perf_stall_cnt is nonzero.
4. Zero length: init_req=1, len=0. Init handshake runs; ram_RAenable never asserted; done pulses after ram_mem_initial_signal.
5. Reset mid-burst: assert rst during the 3rd read of len=8. Next cycle all outputs 0, out_valid=0, no done pulse. A following start with len=2 completes normally.
6. Start while busy: a second start pulse mid-burst is ignored; the original burst length and addresses are unchanged.
